// File: rtl/fc_pkg.sv
// Shared constants for the fully-connected classifier: sizes, ROM depth and FSM encoding.
package fc_pkg;

    localparam int N_IN      = 9;
    localparam int N_CLS     = 4;
    localparam int ACC_W     = 20;
    localparam int ROM_DEPTH = N_IN * N_CLS;
    localparam int ADDR_W    = 6;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/fc_classify_mac_s8.sv
// Signed 8x8 multiply-accumulate; clr restarts the sum from the current product.
module mac_s8
    import fc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic signed [7:0]       a,
    input  logic signed [7:0]       b,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [ACC_W-1:0] acc;
    logic signed [15:0]      prod;

    // sum is the value acc takes at the next edge; the top uses it to commit scores without a bubble.
    always_comb begin
        prod = a * b;
        sum  = (clr ? '0 : acc) + {{(ACC_W-16){prod[15]}}, prod};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/fc_classify.sv
// Nine-input, four-class dense layer: streams weights from an external ROM and reports scores plus argmax.
module fc_classify
    import fc_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [8*N_IN-1:0]           pool_lin_reg,
    output logic                        w_rd_en,
    output logic [ADDR_W-1:0]           w_addr,
    input  logic signed [7:0]           w_data,
    output logic                        busy,
    output logic                        done,
    output logic [N_CLS*ACC_W-1:0]      scores,
    output logic [1:0]                  cls_idx
);

    logic [2:0]              state;
    logic [2:0]              state_nxt;
    logic signed [7:0]       x_reg [N_IN];
    logic [3:0]              i_cnt;
    logic [1:0]              c_cnt;
    logic                    d_valid;
    logic [3:0]              d_i;
    logic [1:0]              d_c;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] score_buf [N_CLS-1];
    logic signed [ACC_W-1:0] best_val;
    logic [1:0]              best_idx;
    logic                    last_in;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_MAC;
            S_MAC:   if (w_addr == ADDR_W'(ROM_DEPTH - 1)) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign w_rd_en = (state == S_MAC);
    assign busy    = (state == S_LATCH) || (state == S_MAC) || (state == S_DRAIN);
    assign done    = (state == S_DONE);
    assign last_in = d_valid && (d_i == 4'(N_IN - 1));

    // NOTE: x_reg is a register array, not a RAM, so clearing it on reset costs nothing special.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            for (int k = 0; k < N_IN; k++) x_reg[k] <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_LATCH) begin
                for (int k = 0; k < N_IN; k++) x_reg[k] <= pool_lin_reg[8*k +: 8];
            end
        end
    end

    // Address walks c*9+i with i/c tracked alongside to avoid a divider on the return path.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_addr  <= '0;
            i_cnt   <= '0;
            c_cnt   <= '0;
            d_valid <= 1'b0;
            d_i     <= '0;
            d_c     <= '0;
        end else begin
            d_valid <= w_rd_en;
            d_i     <= i_cnt;
            d_c     <= c_cnt;
            if (state == S_MAC) begin
                if (state_nxt != S_MAC) begin
                    w_addr <= '0;
                    i_cnt  <= '0;
                    c_cnt  <= '0;
                end else begin
                    w_addr <= w_addr + 1'b1;
                    if (i_cnt == 4'(N_IN - 1)) begin
                        i_cnt <= '0;
                        c_cnt <= c_cnt + 1'b1;
                    end else begin
                        i_cnt <= i_cnt + 1'b1;
                    end
                end
            end
        end
    end

    mac_s8 u_mac (
        .clk (clk),
        .rst (rst),
        .en  (d_valid),
        .clr (d_i == 4'd0),
        .a   (x_reg[d_i]),
        .b   (w_data),
        .sum (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CLS - 1; c++) score_buf[c] <= '0;
            best_val <= '0;
            best_idx <= '0;
        end else if (last_in) begin
            if (d_c != 2'(N_CLS - 1)) score_buf[d_c] <= acc_next;
            // Strict compare keeps the lower index on ties; class 0 always seeds the best.
            if (d_c == 2'd0 || acc_next > best_val) begin
                best_val <= acc_next;
                best_idx <= d_c;
            end
        end
    end

    // Published results change only on entry to DONE; the last class bypasses the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            scores  <= '0;
            cls_idx <= '0;
        end else if (state == S_DRAIN) begin
            for (int c = 0; c < N_CLS - 1; c++) scores[c*ACC_W +: ACC_W] <= score_buf[c];
            scores[(N_CLS-1)*ACC_W +: ACC_W] <= acc_next;
            cls_idx <= (acc_next > best_val) ? 2'(N_CLS - 1) : best_idx;
        end
    end

endmodule

// File: tb/tb_fc_classify.sv
// Self-checking bench for fc_classify: spec vectors, randomized model comparison, and timing/reset corners.
module tb_fc_classify;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [71:0] pool_lin_reg = '0;
    logic        w_rd_en;
    logic [5:0]  w_addr;
    logic signed [7:0] w_data = '0;
    logic        busy;
    logic        done;
    logic [79:0] scores;
    logic [1:0]  cls_idx;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic signed [7:0] rom [36];
    int xv [9];
    int exp_s [4];
    int exp_idx;

    typedef struct {
        int xval;
        int wmode;   // 0: every weight = wval, 1: weight = class+1
        int wval;
        int s0, s1, s2, s3;
        int idx;
    } vec_t;

    fc_classify dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pool_lin_reg (pool_lin_reg),
        .w_rd_en      (w_rd_en),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .busy         (busy),
        .done         (done),
        .scores       (scores),
        .cls_idx      (cls_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ROM with one cycle of read latency.
    always @(posedge clk) if (w_rd_en) w_data <= rom[w_addr];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int get_score(input int c);
        logic signed [19:0] v;
        v = scores[c*20 +: 20];
        return int'(v);
    endfunction

    function automatic void ref_model();
        int best;
        for (int c = 0; c < 4; c++) begin
            exp_s[c] = 0;
            for (int i = 0; i < 9; i++) exp_s[c] += xv[i] * int'(rom[c*9 + i]);
        end
        best = 0;
        for (int c = 1; c < 4; c++) if (exp_s[c] > exp_s[best]) best = c;
        exp_idx = best;
    endfunction

    task automatic check_results(input string tag);
        for (int c = 0; c < 4; c++) check($sformatf("%s score%0d", tag, c), get_score(c), exp_s[c]);
        check({tag, " cls_idx"}, cls_idx, exp_idx);
    endtask

    // Starts one operation, scrambles the input bus after LATCH, and checks the cycle-level protocol.
    task automatic run_op(input bit mid_start, input string tag, output int t_start);
        int dcyc, rel;
        bit seq_ok, busy_ok, hold_ok, exp_rd;
        logic [79:0] held;
        @(posedge clk); #1;
        for (int k = 0; k < 9; k++) pool_lin_reg[8*k +: 8] = 8'(xv[k]);
        start = 1'b1;
        t_start = cyc;
        held = scores;
        dcyc = -1;
        seq_ok = 1'b1; busy_ok = 1'b1; hold_ok = 1'b1;
        for (int k = 0; k < 45 && dcyc < 0; k++) begin
            @(posedge clk); #1;
            start = mid_start && (cyc == t_start + 10);
            if (cyc == t_start + 2) pool_lin_reg = {$urandom, $urandom, $urandom};
            @(negedge clk);
            rel = cyc - t_start;
            exp_rd = (rel >= 2) && (rel <= 37);
            if (w_rd_en !== exp_rd || (exp_rd && w_addr !== 6'(rel - 2))) seq_ok = 1'b0;
            if (busy !== ((rel >= 1) && (rel <= 38))) busy_ok = 1'b0;
            if (rel <= 38 && scores !== held) hold_ok = 1'b0;
            if (done === 1'b1) dcyc = cyc;
        end
        start = 1'b0;
        check({tag, " done_latency"}, (dcyc < 0) ? -1 : dcyc - t_start, 39);
        check({tag, " addr_seq"}, seq_ok, 1);
        check({tag, " busy_window"}, busy_ok, 1);
        check({tag, " scores_hold"}, hold_ok, 1);
    endtask

    vec_t tbl [6];
    int t1, t2;
    bit seen;

    initial begin
        tbl[0] = '{1,    0, 1,    9,      9,      9,      9,      0};
        tbl[1] = '{1,    1, 0,    9,      18,     27,     36,     3};
        tbl[2] = '{-128, 0, -128, 147456, 147456, 147456, 147456, 0};
        tbl[3] = '{127,  0, -128, -146304, -146304, -146304, -146304, 0};
        tbl[4] = '{-1,   1, 0,    -9,     -18,    -27,    -36,    0};
        tbl[5] = '{2,    0, -1,   -18,    -18,    -18,    -18,    0};

        for (int j = 0; j < 36; j++) rom[j] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset w_rd_en", w_rd_en, 0);
        check("reset w_addr", w_addr, 0);
        check("reset scores", (scores == '0), 1);
        check("reset cls_idx", cls_idx, 0);
        #1 rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 9; i++) xv[i] = tbl[v].xval;
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 9; i++)
                    rom[c*9 + i] = 8'((tbl[v].wmode == 1) ? c + 1 : tbl[v].wval);
            run_op(1'b0, $sformatf("vec%0d", v), t1);
            exp_s[0] = tbl[v].s0; exp_s[1] = tbl[v].s1;
            exp_s[2] = tbl[v].s2; exp_s[3] = tbl[v].s3;
            exp_idx = tbl[v].idx;
            check_results($sformatf("vec%0d", v));
        end

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 9; i++) xv[i] = int'($urandom_range(255)) - 128;
            for (int j = 0; j < 36; j++) rom[j] = 8'($urandom_range(255));
            if (r == 0) for (int i = 0; i < 9; i++) xv[i] = -128;
            run_op(1'b0, $sformatf("rnd%0d", r), t1);
            ref_model();
            check_results($sformatf("rnd%0d", r));
        end

        // Spurious start during MAC is ignored; a start right after done is accepted.
        for (int i = 0; i < 9; i++) xv[i] = i - 4;
        for (int j = 0; j < 36; j++) rom[j] = 8'(j - 17);
        run_op(1'b1, "midstart", t1);
        ref_model();
        check_results("midstart");
        for (int i = 0; i < 9; i++) xv[i] = 3 * i - 10;
        run_op(1'b0, "b2b", t2);
        check("b2b second_done", t2 + 39 - t1, 79);
        ref_model();
        check_results("b2b");

        // Reset in the middle of MAC aborts and clears results.
        @(posedge clk); #1;
        start = 1'b1; t1 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < t1 + 20) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst cycle", cyc - t1, 21);
        check("midrst busy", busy, 0);
        check("midrst w_rd_en", w_rd_en, 0);
        check("midrst w_addr", w_addr, 0);
        check("midrst scores", (scores == '0), 1);
        check("midrst cls_idx", cls_idx, 0);
        seen = 1'b0;
        repeat (45) begin @(negedge clk); if (done === 1'b1) seen = 1'b1; end
        check("midrst no_done", seen, 0);

        // Start coincident with reset is ignored.
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        seen = 1'b0;
        repeat (45) begin @(negedge clk); if (busy === 1'b1 || done === 1'b1) seen = 1'b1; end
        check("rst_start ignored", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
